clock_redraw_ctrl: RTL

- Sequences redraws of the 32x32 analog-clock framebuffer.
- On each slow_clk rising edge, or on force_redraw, snapshots the time and alarm inputs. If they differ from the last drawn frame, it walks the row renderer through rows 0..ROWS-1 and writes each returned row into the single-port framebuffer RAM.
- Arbitrates that RAM port against the VGA scanout reader. Scanout has priority, with a bounded-stall guarantee for writes.
- Sits between the timekeeping/alarm logic, the row renderer and the framebuffer memory.

---
 rtl/clock_fb_pkg.sv | 25 ++
 rtl/fb_port_arbiter.sv | 36 +++
 rtl/clock_redraw_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clock_fb_pkg.sv
// Shared types and sizing for the analog-clock framebuffer redraw path.
package clock_fb_pkg;

    localparam int unsigned ROWS      = 32;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ROW_W     = $clog2(ROWS);
    localparam int unsigned MAX_STALL = 8;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        REQ,
        WRITE,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
        logic [3:0] al_hour;
        logic [5:0] al_minute;
    } time_snapshot_t;

endpackage

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: scanout wins, but a pending write is guaranteed
// the port after MAX_STALL consecutive blocked cycles.
module fb_port_arbiter
    import clock_fb_pkg::*;
#(
    parameter int unsigned STALL_MAX = MAX_STALL
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_pending,
    input  logic scan_req,
    output logic fb_we,
    output logic scan_gnt,
    output logic write_done
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    logic [STALL_W-1:0] stall;

    assign fb_we      = wr_pending & (~scan_req | (stall == STALL_W'(STALL_MAX)));
    assign scan_gnt   = scan_req & ~fb_we;
    assign write_done = fb_we;

    // Counts only cycles where a write waits behind scanout.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall <= '0;
        end else if (!wr_pending || fb_we) begin
            stall <= '0;
        end else begin
            stall <= stall + STALL_W'(1);
        end
    end

endmodule

// File: rtl/clock_redraw_ctrl.sv
// Redraw sequencer: snapshots time/alarm on a tick or force, walks the row
// renderer and writes each row into the shared framebuffer port.
module clock_redraw_ctrl
    import clock_fb_pkg::*;
#(
    parameter int unsigned STALL_MAX = MAX_STALL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             force_redraw,
    input  logic [3:0]       hour,
    input  logic [5:0]       minute,
    input  logic [5:0]       second,
    input  logic [3:0]       al_hour,
    input  logic [5:0]       al_minute,
    output logic [3:0]       snap_hour,
    output logic [5:0]       snap_minute,
    output logic [5:0]       snap_second,
    output logic [3:0]       snap_al_hour,
    output logic [5:0]       snap_al_minute,
    output logic             rend_req,
    output logic [ROW_W-1:0] rend_row,
    input  logic             rend_ack,
    input  logic [WIDTH-1:0] rend_data,
    output logic             fb_we,
    output logic [ROW_W-1:0] fb_waddr,
    output logic [WIDTH-1:0] fb_wdata,
    input  logic             scan_req,
    output logic             scan_gnt,
    output logic             busy,
    output logic             frame_done
);

    state_t             state, state_next;
    logic [ROW_W-1:0]   row, row_next;
    logic [WIDTH-1:0]   wbuf, wbuf_next;
    time_snapshot_t     snap, snap_next, last, last_next, live;
    logic               force_first, force_first_next;
    logic               pending, pending_next;
    logic               pend_force, pend_force_next;
    logic               snap_force, snap_force_next;
    logic [2:0]         slow_q;
    logic               trig;
    logic               wr_pending;
    logic               write_done;

    assign live = {hour, minute, second, al_hour, al_minute};
    assign trig = (slow_q[1] & ~slow_q[2]) | force_redraw;

    // Reset kills a write in flight so nothing lands after the abort.
    assign wr_pending = (state == WRITE) & ~reset;

    fb_port_arbiter #(.STALL_MAX(STALL_MAX)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .wr_pending (wr_pending),
        .scan_req   (scan_req),
        .fb_we      (fb_we),
        .scan_gnt   (scan_gnt),
        .write_done (write_done)
    );

    assign snap_hour      = snap.hour;
    assign snap_minute    = snap.minute;
    assign snap_second    = snap.second;
    assign snap_al_hour   = snap.al_hour;
    assign snap_al_minute = snap.al_minute;
    assign rend_row       = row;
    assign fb_waddr       = row;
    assign fb_wdata       = wbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            wbuf        <= '0;
            snap        <= '0;
            last        <= '0;
            force_first <= 1'b1;
            pending     <= 1'b0;
            pend_force  <= 1'b0;
            snap_force  <= 1'b0;
            slow_q      <= '0;
            rend_req    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            row         <= row_next;
            wbuf        <= wbuf_next;
            snap        <= snap_next;
            last        <= last_next;
            force_first <= force_first_next;
            pending     <= pending_next;
            pend_force  <= pend_force_next;
            snap_force  <= snap_force_next;
            slow_q      <= {slow_q[1:0], slow_clk};
            rend_req    <= (state_next == REQ);
            busy        <= (state_next != IDLE);
            frame_done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next       = state;
        row_next         = row;
        wbuf_next        = wbuf;
        snap_next        = snap;
        last_next        = last;
        force_first_next = force_first;
        pending_next     = pending;
        pend_force_next  = pend_force;
        snap_force_next  = snap_force;

        case (state)
            IDLE: begin
                if (trig || pending) begin
                    state_next      = SNAP;
                    pending_next    = 1'b0;
                    pend_force_next = 1'b0;
                    snap_force_next = force_redraw | pend_force;
                end
            end
            SNAP: begin
                snap_next = live;
                if (live == last && !force_first && !snap_force) begin
                    state_next = IDLE;
                end else begin
                    row_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (rend_ack) begin
                    wbuf_next  = rend_data;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (write_done) begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        state_next = DONE;
                    end else begin
                        row_next   = row + ROW_W'(1);
                        state_next = REQ;
                    end
                end
            end
            DONE: begin
                last_next        = snap;
                force_first_next = 1'b0;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Triggers arriving mid-redraw coalesce into a single follow-up.
        if (state != IDLE && trig) begin
            pending_next = 1'b1;
            if (force_redraw) begin
                pend_force_next = 1'b1;
            end
        end
    end

endmodule
